// File: rtl/microcode_step_controller.sv
// Run/halt/single-step controller that sits beside a microcode sequencer.
// Accepts STOP/RUN/USTEP/ISTEP commands and counts completed instructions.
module microcode_step_controller #(
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic        clk4,
    input  logic        reset,
    input  logic [1:0]  cmd,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        nend,
    input  logic        nws,
    input  logic        fpfetch,
    output logic        nhalt,
    output logic        halted,
    output logic        step_done,
    output logic        cmd_err,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        ST_HALTED      = 3'd0,
        ST_RUN         = 3'd1,
        ST_USTEP       = 3'd2,
        ST_ISTEP_END   = 3'd3,
        ST_ISTEP_FETCH = 3'd4
    } state_e;

    localparam logic [1:0] CMD_STOP  = 2'd0;
    localparam logic [1:0] CMD_RUN   = 2'd1;
    localparam logic [1:0] CMD_USTEP = 2'd2;
    localparam logic [1:0] CMD_ISTEP = 2'd3;

    state_e      state_q, state_d;
    logic        nhalt_q, nhalt_d;
    logic        step_done_q, step_done_d;
    logic        cmd_err_q, cmd_err_d;
    logic [15:0] instr_count_q, instr_count_d;
    logic        cmd_accept_s;
    logic        instr_done_s;

    assign cmd_ready    = (state_q == ST_HALTED) || (state_q == ST_RUN);
    assign halted       = (state_q == ST_HALTED);
    assign nhalt        = nhalt_q;
    assign step_done    = step_done_q;
    assign cmd_err      = cmd_err_q;
    assign instr_count  = instr_count_q;
    assign cmd_accept_s = cmd_valid && cmd_ready;
    // An instruction retires whenever the sequencer is released and ends without a wait state.
    assign instr_done_s = (state_q != ST_HALTED) && !nend && nws;

    // Next-state, registered-output and counter logic.
    always_comb begin
        state_d       = state_q;
        step_done_d   = 1'b0;
        cmd_err_d     = 1'b0;
        case (state_q)
            ST_HALTED: begin
                if (cmd_accept_s) begin
                    case (cmd)
                        CMD_RUN:   state_d = ST_RUN;
                        CMD_USTEP: state_d = ST_USTEP;
                        CMD_ISTEP: state_d = ST_ISTEP_END;
                        default:   state_d = ST_HALTED;
                    endcase
                end else begin
                    state_d = ST_HALTED;
                end
            end
            ST_RUN: begin
                if (cmd_accept_s) begin
                    case (cmd)
                        CMD_STOP:  state_d = ST_HALTED;
                        CMD_RUN:   state_d = ST_RUN;
                        default: begin
                            state_d   = ST_RUN;
                            cmd_err_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_USTEP: begin
                if (nws) begin
                    state_d     = ST_HALTED;
                    step_done_d = 1'b1;
                end else begin
                    state_d = ST_USTEP;
                end
            end
            ST_ISTEP_END: begin
                if (!nend && nws) begin
                    state_d = ST_ISTEP_FETCH;
                end else begin
                    state_d = ST_ISTEP_END;
                end
            end
            ST_ISTEP_FETCH: begin
                if (!fpfetch) begin
                    state_d     = ST_HALTED;
                    step_done_d = 1'b1;
                end else begin
                    state_d = ST_ISTEP_FETCH;
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
        nhalt_d = (state_d != ST_HALTED);
        if (instr_done_s) begin
            instr_count_d = instr_count_q + 16'd1;
        end else begin
            instr_count_d = instr_count_q;
        end
    end

    // State and output registers; reset wins over any command or step in flight.
    always_ff @(posedge clk4) begin
        if (reset) begin
            state_q       <= RESET_HALTED ? ST_HALTED : ST_RUN;
            nhalt_q       <= !RESET_HALTED;
            step_done_q   <= 1'b0;
            cmd_err_q     <= 1'b0;
            instr_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            nhalt_q       <= nhalt_d;
            step_done_q   <= step_done_d;
            cmd_err_q     <= cmd_err_d;
            instr_count_q <= instr_count_d;
        end
    end

endmodule

// File: tb/tb_microcode_step_controller.sv
// Vector-table bench driving two controllers (reset-halted and reset-running) in lockstep
// once a STOP has aligned them; expected values queue up at drive time and are checked after the edge.
module tb_microcode_step_controller;

    logic        clk4 = 1'b0;
    logic        reset;
    logic [1:0]  cmd;
    logic        cmd_valid;
    logic        nend;
    logic        nws;
    logic        fpfetch;

    logic        cmd_ready_h, nhalt_h, halted_h, step_done_h, cmd_err_h;
    logic [15:0] instr_count_h;
    logic        cmd_ready_r, nhalt_r, halted_r, step_done_r, cmd_err_r;
    logic [15:0] instr_count_r;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [1:0]  cmd;
        logic        v;
        logic        nend;
        logic        nws;
        logic        fpf;
        logic        e_nhalt;
        logic        e_halted;
        logic        e_rdy;
        logic        e_sd;
        logic        e_err;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[24];
    vec_t sb_q[$];

    localparam logic [1:0] STOP  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] USTEP = 2'd2;
    localparam logic [1:0] ISTEP = 2'd3;

    microcode_step_controller #(.RESET_HALTED(1'b1)) dut_h (
        .clk4(clk4), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_h),
        .nend(nend), .nws(nws), .fpfetch(fpfetch), .nhalt(nhalt_h), .halted(halted_h),
        .step_done(step_done_h), .cmd_err(cmd_err_h), .instr_count(instr_count_h)
    );

    microcode_step_controller #(.RESET_HALTED(1'b0)) dut_r (
        .clk4(clk4), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_r),
        .nend(nend), .nws(nws), .fpfetch(fpfetch), .nhalt(nhalt_r), .halted(halted_r),
        .step_done(step_done_r), .cmd_err(cmd_err_r), .instr_count(instr_count_r)
    );

    always #5 clk4 = ~clk4;

    function automatic vec_t mk(input logic [1:0] c, input logic v, input logic ne, input logic nw,
                                input logic fp, input logic nh, input logic hl, input logic rd,
                                input logic sd, input logic er, input logic [15:0] cnt);
        vec_t r;
        r.cmd = c; r.v = v; r.nend = ne; r.nws = nw; r.fpf = fp;
        r.e_nhalt = nh; r.e_halted = hl; r.e_rdy = rd; r.e_sd = sd; r.e_err = er; r.e_cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] c, input logic v, input logic ne, input logic nw, input logic fp);
        @(negedge clk4);
        cmd = c; cmd_valid = v; nend = ne; nws = nw; fpfetch = fp;
    endtask

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        drive(v.cmd, v.v, v.nend, v.nws, v.fpf);
        sb_q.push_back(v);
        @(posedge clk4);
        #1;
        e = sb_q.pop_front();
        chk({tag, "_nhalt_h"},  {15'd0, nhalt_h},     {15'd0, e.e_nhalt});
        chk({tag, "_halted_h"}, {15'd0, halted_h},    {15'd0, e.e_halted});
        chk({tag, "_ready_h"},  {15'd0, cmd_ready_h}, {15'd0, e.e_rdy});
        chk({tag, "_sdone_h"},  {15'd0, step_done_h}, {15'd0, e.e_sd});
        chk({tag, "_err_h"},    {15'd0, cmd_err_h},   {15'd0, e.e_err});
        chk({tag, "_count_h"},  instr_count_h,        e.e_cnt);
        chk({tag, "_nhalt_r"},  {15'd0, nhalt_r},     {15'd0, e.e_nhalt});
        chk({tag, "_halted_r"}, {15'd0, halted_r},    {15'd0, e.e_halted});
        chk({tag, "_ready_r"},  {15'd0, cmd_ready_r}, {15'd0, e.e_rdy});
        chk({tag, "_sdone_r"},  {15'd0, step_done_r}, {15'd0, e.e_sd});
        chk({tag, "_err_r"},    {15'd0, cmd_err_r},   {15'd0, e.e_err});
        chk({tag, "_count_r"},  instr_count_r,        e.e_cnt);
    endtask

    initial begin
        reset = 1'b1; cmd = STOP; cmd_valid = 1'b0; nend = 1'b1; nws = 1'b1; fpfetch = 1'b1;

        // USTEP held by three wait states, then completion
        vecs[0]  = mk(USTEP, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[1]  = mk(STOP,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[2]  = mk(STOP,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[3]  = mk(STOP,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[4]  = mk(STOP,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
        vecs[5]  = mk(STOP,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        // USTEP finishing on an end-of-instruction edge also counts
        vecs[6]  = mk(USTEP, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[7]  = mk(STOP,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1);
        // ISTEP: low fpfetch ignored in END, end with wait state ignored, busy command ignored
        vecs[8]  = mk(ISTEP, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        vecs[9]  = mk(STOP,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        vecs[10] = mk(STOP,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        vecs[11] = mk(STOP,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
        vecs[12] = mk(RUN,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
        vecs[13] = mk(STOP,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
        vecs[14] = mk(STOP,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2);
        vecs[15] = mk(STOP,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2);
        // RUN: illegal step commands flag errors, RUN is a no-op, STOP halts
        vecs[16] = mk(RUN,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
        vecs[17] = mk(ISTEP, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2);
        vecs[18] = mk(STOP,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
        vecs[19] = mk(USTEP, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2);
        vecs[20] = mk(RUN,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
        vecs[21] = mk(RUN,   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3);
        vecs[22] = mk(STOP,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3);
        vecs[23] = mk(STOP,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3);

        @(posedge clk4);
        #1;
        chk("rst_nhalt_h",  {15'd0, nhalt_h},     16'd0);
        chk("rst_halted_h", {15'd0, halted_h},    16'd1);
        chk("rst_ready_h",  {15'd0, cmd_ready_h}, 16'd1);
        chk("rst_count_h",  instr_count_h,        16'd0);
        chk("rst_nhalt_r",  {15'd0, nhalt_r},     16'd1);
        chk("rst_halted_r", {15'd0, halted_r},    16'd0);
        chk("rst_ready_r",  {15'd0, cmd_ready_r}, 16'd1);
        chk("rst_count_r",  instr_count_r,        16'd0);
        @(negedge clk4);
        reset = 1'b0;

        // STOP aligns both: no-op when halted, halts the running one
        apply(mk(STOP, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0), "sync");

        for (int i = 0; i < 24; i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Counter wrap: run until 0xFFFF, one more retirement wraps, wait state blocks counting
        apply(mk(RUN, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3), "wrap_run");
        for (int i = 0; i < 65531; i++) begin
            drive(STOP, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        apply(mk(STOP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF), "wrap_max");
        apply(mk(STOP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000), "wrap_zero");
        apply(mk(STOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000), "wrap_ws");

        // Reset arriving mid-ISTEP_FETCH on an edge that would otherwise complete
        apply(mk(STOP,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0), "mr_stop");
        apply(mk(ISTEP, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0), "mr_istep");
        apply(mk(STOP,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1), "mr_end");
        apply(mk(STOP,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1), "mr_fetch");
        @(negedge clk4);
        reset = 1'b1; cmd = ISTEP; cmd_valid = 1'b1; nend = 1'b0; nws = 1'b1; fpfetch = 1'b0;
        @(posedge clk4);
        #1;
        chk("mr_nhalt_r",  {15'd0, nhalt_r},     16'd1);
        chk("mr_halted_r", {15'd0, halted_r},    16'd0);
        chk("mr_ready_r",  {15'd0, cmd_ready_r}, 16'd1);
        chk("mr_sdone_r",  {15'd0, step_done_r}, 16'd0);
        chk("mr_count_r",  instr_count_r,        16'd0);
        chk("mr_halted_h", {15'd0, halted_h},    16'd1);
        chk("mr_sdone_h",  {15'd0, step_done_h}, 16'd0);
        chk("mr_count_h",  instr_count_h,        16'd0);
        drive(STOP, 1'b0, 1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        @(posedge clk4);
        #1;
        chk("mr_post_sdone_r",  {15'd0, step_done_r}, 16'd0);
        chk("mr_post_nhalt_r",  {15'd0, nhalt_r},     16'd1);
        chk("mr_post_count_r",  instr_count_r,        16'd0);
        chk("mr_post_sdone_h",  {15'd0, step_done_h}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/microcode_step_controller.md
MICROCODE_STEP_CONTROLLER -- requirements
Module: microcode_step_controller

Interface
REQ-001 Parameter RESET_HALTED, default 0, meaning: 1 = enter HALTED at reset, 0 = enter RUN at reset.
REQ-002 clk4  input  1  processor clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd  input  2  command code: 0 STOP, 1 RUN, 2 USTEP (one microstep), 3 ISTEP (one instruction).
REQ-005 cmd_valid  input  1  command present; accepted on an edge where cmd_valid=1 and cmd_ready=1.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 nend  input  1  active-low end-of-instruction from the sequencer.
REQ-008 nws  input  1  active-low wait state; the micro-PC advances only on edges where nws=1.
REQ-009 fpfetch  input  1  high while the micro-PC is in the fetch phase (uPC<2).
REQ-010 nhalt  output  1  active-low halt to the sequencer; registered.
REQ-011 halted  output  1  high in HALTED state.
REQ-012 step_done  output  1  one-cycle pulse when a USTEP or ISTEP completes.
REQ-013 cmd_err  output  1  one-cycle pulse when an accepted command is illegal in the current state.
REQ-014 instr_count  output  16  count of completed instructions.

Function
REQ-015 States: HALTED, RUN, USTEP, ISTEP_END, ISTEP_FETCH; one-hot or binary encoding is permitted.
REQ-016 nhalt SHALL be 0 in HALTED and 1 in every other state; it is registered and changes on the same edge as the state.
REQ-017 cmd_ready SHALL be 1 in HALTED and RUN, and 0 in USTEP, ISTEP_END and ISTEP_FETCH.
REQ-018 In HALTED: RUN -> RUN; USTEP -> USTEP; ISTEP -> ISTEP_END; STOP is a no-op with no cmd_err.
REQ-019 In RUN: STOP -> HALTED on the accepting edge; RUN is a no-op; USTEP or ISTEP leaves the state unchanged and pulses cmd_err on the next cycle.
REQ-020 USTEP: on the first edge with nws=1 -> HALTED and step_done=1 for one cycle; the uPC advances exactly once.
REQ-021 ISTEP_END: on the first edge with nend=0 and nws=1 -> ISTEP_FETCH.
REQ-022 ISTEP_FETCH: on the first edge with fpfetch=0 -> HALTED and step_done=1 for one cycle.
REQ-023 If nend=0 and nws=1 occur on the same edge that USTEP completes, both the USTEP completion and the instr_count increment SHALL occur.
REQ-024 instr_count SHALL increment by 1 on every edge where state!=HALTED, nend=0 and nws=1; it wraps from 0xFFFF to 0x0000.
REQ-025 Step states have no timeout; a stuck nws or nend holds the state until reset.
REQ-026 Command decode latency is 1 edge; state transitions, nhalt, step_done and cmd_err are all visible in the cycle after the accepting or completing edge.

Reset
REQ-027 While reset=1 at an edge, the block SHALL set state to HALTED if RESET_HALTED=1 (nhalt=0, halted=1), otherwise RUN (nhalt=1, halted=0).
REQ-028 The same reset SHALL clear instr_count to 0 and step_done and cmd_err to 0.
REQ-029 Reset SHALL override any command or step in progress on the same edge, including mid-ISTEP.

Verification
REQ-030 RESET_HALTED=1, reset 1 cycle -> nhalt=0, halted=1, cmd_ready=1, instr_count=0x0000.
REQ-031 HALTED, USTEP accepted, nws=0 for 3 cycles then 1 -> nhalt=1 for 4 cycles, then HALTED, step_done pulses once, exactly one nws=1 edge seen with nhalt=1.
REQ-032 HALTED, ISTEP accepted, nend=0 with nws=1 at cycle 5, fpfetch high for cycles 6-7, low at cycle 8 -> HALTED after the cycle-8 edge, step_done=1 once, instr_count +1, cmd_ready=0 throughout.
REQ-033 RUN, ISTEP command -> cmd_err pulses 1 cycle, state stays RUN, nhalt=1; then STOP -> nhalt=0 next cycle.
REQ-034 instr_count preloaded via 0xFFFF completions, one more nend=0/nws=1 edge in RUN -> instr_count=0x0000; nend=0 with nws=0 -> no increment.
REQ-035 Mid-ISTEP_FETCH, reset=1 with RESET_HALTED=0 -> RUN next cycle, no step_done, instr_count=0.
